// File: rtl/ex_mem.sv
// Execute-to-memory pipeline register, plus the madd/msub accumulate state returned to execute.
// Latency: 1 cycle from ex_* to mem_*; every output is a flop, with no combinational path.
// Backpressure: flush clears everything; an execute-only stall inserts a bubble; a joint stall holds all state.
module ex_mem #(
    parameter int DATA_W     = 32,
    parameter int ALUOP_W    = 8,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic                  ex_cp0_reg_we,
    input  logic [REG_ADDR_W-1:0] ex_cp0_reg_write_addr,
    input  logic [DATA_W-1:0]     ex_cp0_reg_data,
    input  logic                  ex_is_in_delay_slot,
    input  logic [DATA_W-1:0]     ex_current_inst_address,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic                  mem_cp0_reg_we,
    output logic [REG_ADDR_W-1:0] mem_cp0_reg_write_addr,
    output logic [DATA_W-1:0]     mem_cp0_reg_data,
    output logic                  mem_is_in_delay_slot,
    output logic [DATA_W-1:0]     mem_current_inst_address,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    // All fields handed to the memory stage, grouped so clear/hold/load act on one bus.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic [DATA_W-1:0]     hi;
        logic [DATA_W-1:0]     lo;
        logic                  whilo;
        logic [ALUOP_W-1:0]    aluop;
        logic [DATA_W-1:0]     mem_addr;
        logic [DATA_W-1:0]     reg2;
        logic                  cp0_reg_we;
        logic [REG_ADDR_W-1:0] cp0_reg_write_addr;
        logic [DATA_W-1:0]     cp0_reg_data;
        logic                  is_in_delay_slot;
        logic [DATA_W-1:0]     current_inst_address;
    } stage_t;

    stage_t              ex_s;
    stage_t              stage_d, stage_q;
    logic [2*DATA_W-1:0] hilo_d, hilo_q;
    logic [1:0]          cnt_d, cnt_q;

    logic ex_stall, mem_stall;
    logic unused_stall_bits;

    assign ex_stall          = stall[3];
    assign mem_stall         = stall[4];
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

    // Gather the execute-stage results into one bus.
    always_comb begin
        ex_s                      = '0;
        ex_s.wd                   = ex_wd;
        ex_s.wreg                 = ex_wreg;
        ex_s.wdata                = ex_wdata;
        ex_s.hi                   = ex_hi;
        ex_s.lo                   = ex_lo;
        ex_s.whilo                = ex_whilo;
        ex_s.aluop                = ex_aluop;
        ex_s.mem_addr             = ex_mem_addr;
        ex_s.reg2                 = ex_reg2;
        ex_s.cp0_reg_we           = ex_cp0_reg_we;
        ex_s.cp0_reg_write_addr   = ex_cp0_reg_write_addr;
        ex_s.cp0_reg_data         = ex_cp0_reg_data;
        ex_s.is_in_delay_slot     = ex_is_in_delay_slot;
        ex_s.current_inst_address = ex_current_inst_address;
    end

    // Next-state selection: flush beats bubble, bubble beats advance, joint stall holds.
    always_comb begin
        stage_d = stage_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        if (flush) begin
            stage_d = '0;
            hilo_d  = '0;
            cnt_d   = '0;
        end else if (ex_stall && !mem_stall) begin
            // Bubble: memory sees a NOP while the accumulate partial survives the stall.
            stage_d = '0;
            hilo_d  = hilo_i;
            cnt_d   = cnt_i;
        end else if (!ex_stall) begin
            // Advance; the illegal mem-only stall also lands here.
            stage_d = ex_s;
            hilo_d  = '0;
            cnt_d   = '0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
            hilo_q  <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_wd                   = stage_q.wd;
    assign mem_wreg                 = stage_q.wreg;
    assign mem_wdata                = stage_q.wdata;
    assign mem_hi                   = stage_q.hi;
    assign mem_lo                   = stage_q.lo;
    assign mem_whilo                = stage_q.whilo;
    assign mem_aluop                = stage_q.aluop;
    assign mem_mem_addr             = stage_q.mem_addr;
    assign mem_reg2                 = stage_q.reg2;
    assign mem_cp0_reg_we           = stage_q.cp0_reg_we;
    assign mem_cp0_reg_write_addr   = stage_q.cp0_reg_write_addr;
    assign mem_cp0_reg_data         = stage_q.cp0_reg_data;
    assign mem_is_in_delay_slot     = stage_q.is_in_delay_slot;
    assign mem_current_inst_address = stage_q.current_inst_address;
    assign hilo_o                   = hilo_q;
    assign cnt_o                    = cnt_q;

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Captures every execute-stage result each cycle:
  - GPR write-back fields
  - HI/LO write
  - load/store aluop, address and store data
  - CP0 write fields
  - delay-slot flag and instruction address
- Implements stall hold, bubble insertion and exception flush.
- Returns the execute stage's multi-cycle accumulate state (64-bit hilo_temp plus 2-bit cycle counter) so madd/msub can span two cycles while execute is stalled.

Parameters:
- DATA_W, 32, width of data/address words
- ALUOP_W, 8, width of aluop bus
- REG_ADDR_W, 5, GPR/CP0 register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  6  pipeline stall vector; bit3 = execute stalled, bit4 = memory stalled
- flush  in  1  exception flush from ctrl; clears register contents
- ex_wd  in  REG_ADDR_W  destination GPR
- ex_wreg  in  1  GPR write enable
- ex_wdata  in  DATA_W  GPR write data
- ex_hi  in  DATA_W  HI write value
- ex_lo  in  DATA_W  LO write value
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  ALUOP_W  aluop, used by memory stage for load/store decode
- ex_mem_addr  in  DATA_W  effective load/store address
- ex_reg2  in  DATA_W  store data
- ex_cp0_reg_we  in  1  CP0 write enable
- ex_cp0_reg_write_addr  in  REG_ADDR_W  CP0 register address
- ex_cp0_reg_data  in  DATA_W  CP0 write data
- ex_is_in_delay_slot  in  1  instruction sits in a branch delay slot
- ex_current_inst_address  in  DATA_W  PC of the instruction
- hilo_i  in  2*DATA_W  accumulate partial product from execute
- cnt_i  in  2  accumulate cycle counter from execute
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2, mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data, mem_is_in_delay_slot, mem_current_inst_address  out  widths as the matching ex_* inputs  registered copies to the memory stage
- hilo_o  out  2*DATA_W  registered partial product back to execute
- cnt_o  out  2  registered counter back to execute

Behaviour:
- All outputs are registers; there is no combinational path from input to output.
- Reset (rst = 0): all outputs go to 0 immediately, independent of clk, and stay 0 until rst = 1. Reset has priority over everything else.
- On each rising edge with rst = 1, the first matching rule below applies, in this priority order:
  1. flush = 1:
     - All mem_* outputs, hilo_o and cnt_o are set to 0.
     - Flush overrides any stall.
  2. stall[3] = 1 and stall[4] = 0 (bubble):
     - All mem_* outputs are set to 0, so mem_wreg = mem_whilo = mem_cp0_reg_we = 0 and mem_aluop = NOP (0).
     - hilo_o <= hilo_i and cnt_o <= cnt_i, preserving the accumulate state across the execute stall.
  3. stall[3] = 0 (advance):
     - Every mem_* output takes its ex_* input.
     - hilo_o <= 0 and cnt_o <= 0.
  4. Otherwise (stall[3] = 1 and stall[4] = 1, hold):
     - All outputs keep their values, including hilo_o and cnt_o.
- Latency: exactly 1 cycle from ex_* input to mem_* output.
- Accumulate sequence, with execute stalled for one cycle:
  - Cycle 1: execute asserts the stall, presents hilo_i = product and cnt_i = 1. A bubble is inserted and hilo_o/cnt_o capture those values.
  - Cycle 2: execute reads hilo_o/cnt_o, releases the stall and presents the final HI/LO. This advances, and hilo_o/cnt_o return to 0.
- stall[4] = 1 with stall[3] = 0 is an illegal combination; ctrl never issues it. The implementation treats it as the advance rule and verification does not cover it.
- No arithmetic is performed; widths pass through unchanged.

Test Plan:
- Reset mid-operation: drive ex_wdata = 0x12345678, ex_wreg = 1, clock once, then drop rst to 0 between edges -> every output reads 0 before the next edge and stays 0 while rst = 0.
- Advance: stall = 0, ex_wd = 5, ex_wreg = 1, ex_wdata = 0xDEADBEEF, ex_whilo = 1, ex_hi = 0x1, ex_lo = 0x2 -> one edge later mem_wd = 5, mem_wdata = 0xDEADBEEF, mem_hi = 1, mem_lo = 2, hilo_o = 0, cnt_o = 0.
- Bubble with accumulate: stall = 6'b001111, hilo_i = 0x00000001_FFFFFFFE, cnt_i = 1, ex_wreg = 1 -> next edge mem_wreg = 0, mem_aluop = 0, hilo_o = 0x00000001_FFFFFFFE, cnt_o = 1; then stall = 0 -> next edge hilo_o = 0, cnt_o = 0, mem_* = ex_*.
- Hold: load mem_wdata = 0xAAAA5555, then stall = 6'b011111 for 3 edges while ex_* change -> mem_wdata stays 0xAAAA5555 and hilo_o/cnt_o stay unchanged.
- Flush priority: stall = 6'b011111, flush = 1, with non-zero state held -> next edge all outputs 0, including hilo_o and cnt_o.
- CP0/delay-slot pass-through: ex_cp0_reg_we = 1, ex_cp0_reg_write_addr = 12, ex_cp0_reg_data = 0x0000FF01, ex_is_in_delay_slot = 1, ex_current_inst_address = 0x80000020, stall = 0 -> next edge the matching mem_* outputs carry these exact values.
